// File: rtl/wdg_rst_ctrl.sv
// System reset controller: synchronizes the watchdog request, stretches it into a
// minimum-width system reset with enforced cooldown, and records sticky causes plus a saturating count.
module wdg_rst_ctrl #(
  parameter int SYNC_STAGES  = 2,
  parameter int HOLD_CYC     = 16,
  parameter int COOLDOWN_CYC = 4,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wdg_rst_i,
  input  logic                 sw_rst_req_i,
  input  logic                 clr_i,
  output logic                 sys_rst_o,
  output logic                 rst_busy_o,
  output logic                 wdg_flag_o,
  output logic                 sw_flag_o,
  output logic [CNT_WIDTH-1:0] rst_cnt_o
);

  localparam int MAX_CYC = (HOLD_CYC > COOLDOWN_CYC) ? HOLD_CYC : COOLDOWN_CYC;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TW-1:0]        HOLD_LD = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0]        COOL_LD = TW'(COOLDOWN_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_WAIT_LOW, S_COOLDOWN} state_t;

  state_t                 r_state, w_next;
  logic [TW-1:0]          r_tmr, w_tmr_nxt;
  logic                   r_pend, w_pend_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_wdg_s_d;
  logic                   w_wdg_s, w_wdg_ev, w_req, w_inc;
  logic [CNT_WIDTH-1:0]   w_cnt_nxt;

  assign w_wdg_s  = r_sync[SYNC_STAGES-1];
  assign w_wdg_ev = w_wdg_s & ~r_wdg_s_d;
  assign w_req    = w_wdg_ev | sw_rst_req_i;

  always_comb begin
    w_next     = r_state;
    w_tmr_nxt  = r_tmr;
    w_pend_nxt = r_pend;
    w_inc      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_next    = S_ASSERT;
          w_tmr_nxt = HOLD_LD;
          w_inc     = 1'b1;
        end
      end
      S_ASSERT: begin
        if (r_tmr == '0) begin
          if (w_wdg_s) begin
            w_next = S_WAIT_LOW;
          end else begin
            w_next    = S_COOLDOWN;
            w_tmr_nxt = COOL_LD;
          end
        end else begin
          w_tmr_nxt = r_tmr - TW'(1);
        end
      end
      S_WAIT_LOW: begin
        if (!w_wdg_s) begin
          w_next    = S_COOLDOWN;
          w_tmr_nxt = COOL_LD;
        end
      end
      S_COOLDOWN: begin
        // A request landing on the last cooldown cycle is honoured directly rather than lost.
        if (r_tmr == '0) begin
          if (r_pend || w_req) begin
            w_next     = S_ASSERT;
            w_tmr_nxt  = HOLD_LD;
            w_pend_nxt = 1'b0;
            w_inc      = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end else begin
          w_tmr_nxt = r_tmr - TW'(1);
          if (w_req) w_pend_nxt = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt = rst_cnt_o;
    if (clr_i) begin
      w_cnt_nxt = w_inc ? CNT_ONE : '0;
    end else if (w_inc && (rst_cnt_o != '1)) begin
      w_cnt_nxt = rst_cnt_o + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_ASSERT;
      r_tmr      <= HOLD_LD;
      r_pend     <= 1'b0;
      r_sync     <= '0;
      r_wdg_s_d  <= 1'b0;
      sys_rst_o  <= 1'b1;
      rst_busy_o <= 1'b1;
      wdg_flag_o <= 1'b0;
      sw_flag_o  <= 1'b0;
      rst_cnt_o  <= '0;
    end else begin
      r_state    <= w_next;
      r_tmr      <= w_tmr_nxt;
      r_pend     <= w_pend_nxt;
      r_sync     <= {r_sync[SYNC_STAGES-2:0], wdg_rst_i};
      r_wdg_s_d  <= w_wdg_s;
      sys_rst_o  <= (w_next == S_ASSERT) || (w_next == S_WAIT_LOW);
      rst_busy_o <= (w_next != S_IDLE);
      wdg_flag_o <= w_wdg_ev | (wdg_flag_o & ~clr_i);
      sw_flag_o  <= sw_rst_req_i | (sw_flag_o & ~clr_i);
      rst_cnt_o  <= w_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_wdg_rst_ctrl.sv
// Self-checking bench for wdg_rst_ctrl: scoreboard of expected reset pulse widths
// plus per-scenario inline checks of latency, flags and counters.
module tb_wdg_rst_ctrl;

  logic       clk = 1'b0;
  logic       rst, wdg, sw, clr;
  logic       sys_rst, busy, wflag, sflag;
  logic [7:0] cnt;
  logic       sys_rst2, busy2, wflag2, sflag2;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic exp_wflag = 1'b0;
  logic exp_sflag = 1'b0;
  int sb[$];
  int hi_cycles = 0;

  wdg_rst_ctrl #(.SYNC_STAGES(2), .HOLD_CYC(16), .COOLDOWN_CYC(4), .CNT_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .wdg_rst_i(wdg), .sw_rst_req_i(sw), .clr_i(clr),
    .sys_rst_o(sys_rst), .rst_busy_o(busy), .wdg_flag_o(wflag), .sw_flag_o(sflag),
    .rst_cnt_o(cnt)
  );

  wdg_rst_ctrl #(.SYNC_STAGES(2), .HOLD_CYC(16), .COOLDOWN_CYC(4), .CNT_WIDTH(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .wdg_rst_i(wdg), .sw_rst_req_i(sw), .clr_i(clr),
    .sys_rst_o(sys_rst2), .rst_busy_o(busy2), .wdg_flag_o(wflag2), .sw_flag_o(sflag2),
    .rst_cnt_o(cnt2)
  );

  always #5 clk = ~clk;

  // Pulse-width monitor: each completed sys_rst_o pulse pops one expected width.
  always @(negedge clk) begin
    if (rst) begin
      hi_cycles = 0;
    end else if (sys_rst) begin
      hi_cycles++;
    end else if (hi_cycles > 0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected: width %0d, no pulse expected", hi_cycles);
      end else begin
        int e;
        e = sb.pop_front();
        if (hi_cycles !== e) begin
          errors++;
          $display("FAIL pulse_width: got %0d cycles, expected %0d", hi_cycles, e);
        end
      end
      hi_cycles = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string name);
    int e8, e2;
    e8 = (exp_cnt > 255) ? 255 : exp_cnt;
    e2 = (exp_cnt > 3) ? 3 : exp_cnt;
    checks++;
    if (wflag !== exp_wflag || sflag !== exp_sflag || cnt !== 8'(e8) || cnt2 !== 2'(e2)) begin
      errors++;
      $display("FAIL %s: wflag=%b sflag=%b cnt=%0d cnt2=%0d, expected wflag=%b sflag=%b cnt=%0d cnt2=%0d",
               name, wflag, sflag, cnt, cnt2, exp_wflag, exp_sflag, e8, e2);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout: busy=%b after %0d cycles, expected 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wdg = 1'b0; sw = 1'b0; clr = 1'b0;
    repeat (3) tick();
    checks++;
    if (sys_rst !== 1'b1 || busy !== 1'b1 || sys_rst2 !== 1'b1 || busy2 !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: sys_rst=%b busy=%b, expected 1 1", sys_rst, busy);
    end
    check_state("reset_flags_cnt");
    sb.push_back(16);
    rst = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      tick();
      checks++;
      if (sys_rst !== (k < 16) || busy !== (k < 20)) begin
        errors++;
        $display("FAIL poweron_seq: cycle %0d sys_rst=%b busy=%b, expected %b %b",
                 k, sys_rst, busy, (k < 16), (k < 20));
      end
    end
    check_state("poweron_flags_cnt");
  endtask

  task automatic test_sw_reset();
    sw = 1'b1;
    exp_sflag = 1'b1; exp_cnt++; sb.push_back(16);
    tick();
    sw = 1'b0;
    checks++;
    if (sys_rst !== 1'b1) begin
      errors++;
      $display("FAIL sw_latency: sys_rst=%b one edge after request, expected 1", sys_rst);
    end
    check_state("sw_flag_cnt");
    wait_idle("sw_reset");
  endtask

  task automatic test_long_wdg();
    int n;
    wdg = 1'b1;
    exp_wflag = 1'b1; exp_cnt++; sb.push_back(40);
    n = 0;
    do begin tick(); n++; end while (!sys_rst && n < 10);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL wdg_rise_latency: rose after %0d edges, expected 3", n);
    end
    check_state("wdg_flag_cnt");
    repeat (40 - n) tick();
    wdg = 1'b0;
    n = 0;
    do begin tick(); n++; end while (sys_rst && n < 10);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL wdg_fall_latency: fell after %0d edges, expected 3", n);
    end
    wait_idle("long_wdg");
  endtask

  task automatic test_merge_pend();
    int n;
    sw = 1'b1;
    exp_cnt++; sb.push_back(16);
    tick();
    sw = 1'b0;
    repeat (4) tick();
    sw = 1'b1;
    tick();
    sw = 1'b0;
    check_state("merge_no_count");
    n = 0;
    while (sys_rst && n < 30) begin tick(); n++; end
    checks++;
    if (sys_rst !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL merge_to_cooldown: sys_rst=%b busy=%b, expected 0 1", sys_rst, busy);
    end
    sw = 1'b1;
    exp_cnt++; sb.push_back(16);
    tick();
    sw = 1'b0;
    n = 1;
    while (!sys_rst && n < 10) begin tick(); n++; end
    checks++;
    if (n !== 4 || sys_rst !== 1'b1) begin
      errors++;
      $display("FAIL pend_gap: reasserted after %0d low cycles (sys_rst=%b), expected 4", n, sys_rst);
    end
    check_state("pend_count");
    wait_idle("merge_pend");
  endtask

  task automatic test_clear();
    clr = 1'b1;
    exp_wflag = 1'b0; exp_sflag = 1'b0; exp_cnt = 0;
    tick();
    clr = 1'b0;
    check_state("clr_alone");
    tick();
    clr = 1'b1; sw = 1'b1;
    exp_sflag = 1'b1; exp_cnt = 1; sb.push_back(16);
    tick();
    clr = 1'b0; sw = 1'b0;
    check_state("clr_with_sw");
    wait_idle("clear");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      sw = 1'b1;
      exp_cnt++; sb.push_back(16);
      tick();
      sw = 1'b0;
      wait_idle("saturation");
    end
    check_state("saturation_cnt");
  endtask

  task automatic test_async_reset();
    wdg = 1'b1;
    exp_wflag = 1'b1; exp_cnt++;
    repeat (25) tick();
    checks++;
    if (sys_rst !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_low_hold: sys_rst=%b busy=%b, expected 1 1", sys_rst, busy);
    end
    check_state("wait_low_flags");
    // The in-flight pulse is cut by reset, so it never completes on the scoreboard.
    rst = 1'b1; wdg = 1'b0;
    exp_wflag = 1'b0; exp_sflag = 1'b0; exp_cnt = 0;
    #1;
    checks++;
    if (sys_rst !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL async_reset_out: sys_rst=%b busy=%b, expected 1 1", sys_rst, busy);
    end
    check_state("async_reset_clear");
    tick();
    tick();
    sb.push_back(16);
    rst = 1'b0;
    wait_idle("async_reset");
    check_state("after_async_reset");
  endtask

  initial begin
    test_reset();
    test_sw_reset();
    test_long_wdg();
    test_merge_pend();
    test_clear();
    test_saturation();
    test_async_reset();
    repeat (3) tick();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL pulses_missing: %0d expected pulses never observed, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
